// File: rtl/section_value_streamer.sv
// Steps the calculator's section index from 0 to NUM_SECT-1, shadows each section's
// lane bus, and streams the lanes one word per accepted valid/ready beat.
module section_value_streamer #(
  parameter int NUM_SECT = 16,
  parameter int LANES    = 30,
  parameter int WIDTH    = 18
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   start,
  input  logic [LANES*WIDTH-1:0] load_val,
  output logic [3:0]             sectnum,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4:0]             out_lane,
  output logic [3:0]             out_sect,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [4:0] LAST_LANE = 5'(LANES - 1);
  localparam logic [3:0] LAST_SECT = 4'(NUM_SECT - 1);

  state_t                 state;
  logic [4:0]             lane;
  logic [LANES*WIDTH-1:0] shadow;
  logic [WIDTH-1:0]       lane_word [LANES];
  logic                   accept;

  assign accept = (state == STREAM) && out_ready;

  // NOTE: every register here uses non-blocking assignment so all state updates
  // see the pre-edge values; blocking assignments would create order-dependent races.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      sectnum <= '0;
      lane    <= '0;
      // NOTE: the shadow is a plain register bank, not a RAM, so it is reset;
      // this is what makes out_data read 0 straight out of reset.
      shadow  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sectnum <= '0;
            lane    <= '0;
            state   <= LOAD;
          end
        end
        LOAD: begin
          shadow <= load_val;
          state  <= STREAM;
        end
        STREAM: begin
          if (accept) begin
            if (lane != LAST_LANE) begin
              lane <= lane + 5'd1;
            end else if (sectnum != LAST_SECT) begin
              sectnum <= sectnum + 4'd1;
              lane    <= '0;
              state   <= LOAD;
            end else begin
              state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Split the shadow into lanes so the output mux reads as a plain array index.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_word[i] = shadow[i*WIDTH +: WIDTH];
    end
  end

  // NOTE: out_data gets an explicit value on the out-of-range path so this
  // combinational mux can never infer a latch.
  always_comb begin
    out_data = '0;
    if (int'(lane) < LANES) begin
      out_data = lane_word[lane];
    end
  end

  // Everything below decodes registered state only; out_ready never reaches out_valid.
  assign out_valid = (state == STREAM);
  assign out_lane  = lane;
  assign out_sect  = sectnum;
  assign out_last  = (state == STREAM) && (lane == LAST_LANE) && (sectnum == LAST_SECT);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: doc/section_value_streamer.md
# section_value_streamer

Sequential consumer of the per-section initial-value bus. It steps the 4-bit section number presented to the initial value calculator from 0 to NUM_SECT-1. For each section it captures the 540-bit, 30-lane `load_val` bus into a shadow register and streams the lanes out one 18-bit word per accepted beat over a valid/ready interface. It sits between the initial value calculator and any downstream serial consumer, such as a scanline or memory writer.

## Interface
- NUM_SECT, 16: sections per run, 1..16.
- LANES, 30: lanes per section; fixed by the calculator.
- WIDTH, 18: bits per lane value.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a run; ignored unless in IDLE.
- load_val  in  540  calculator output; lane i occupies bits [18*(i+1)-1 : 18*i].
- sectnum  out  4  section index driven to the calculator.
- out_data  out  18  current lane value.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the beat when high together with out_valid.
- out_lane  out  5  lane index of out_data, 0..29.
- out_sect  out  4  section index of out_data.
- out_last  out  1  high with the final beat of the run: last lane of the last section.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the final beat is accepted.

## Operation
- States: IDLE, LOAD, STREAM, DONE.
- IDLE → LOAD when start=1. On that edge:
  - sectnum ← 0;
  - lane counter ← 0.
- LOAD lasts exactly one cycle and allows the combinational calculator to settle. At the end of LOAD:
  - shadow[539:0] ← load_val;
  - state ← STREAM.
- STREAM:
  - out_valid=1.
  - out_data = shadow lane[lane counter].
  - out_lane = lane counter.
  - out_sect = sectnum.
  - A beat is accepted when out_valid & out_ready.
  - Accepted beat with lane < 29: lane counter increments; state stays STREAM.
  - Accepted beat with lane = 29 and sectnum < NUM_SECT-1: sectnum increments, lane counter ← 0, state ← LOAD.
  - Accepted beat with lane = 29 and sectnum = NUM_SECT-1: state ← DONE.
- DONE lasts one cycle with done=1, then returns to IDLE. sectnum holds its last value.
- out_last = STREAM & (lane = 29) & (sectnum = NUM_SECT-1).
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_lane, out_sect and out_last hold stable. Nothing advances.
- The block does no arithmetic on lane values; it passes them through bit-exact. Each streamed word equals (corner_b − res·(30·s + lane)) mod 2^18, which is the calculator's value truncated to 18 bits.
- Upstream requirement: the calculator's corner_b and res inputs stay stable from start until done.
- start while busy: ignored; it does not restart the run and is not queued.
- NUM_SECT=1: after lane 29 of section 0 the FSM goes directly to DONE.
- Reset:
  - state ← IDLE.
  - sectnum, lane counter, out_lane, out_sect ← 0.
  - shadow ← 0, so out_data = 0.
  - out_valid, out_last, busy, done ← 0.
  - Reset mid-run aborts immediately. No done pulse is produced, and a new start is required.

## Timing
- start sampled high at edge T0: LOAD during cycle T0→T1; out_valid=1 from T1.
- The first beat can be accepted at edge T2. Start-to-first-valid latency is 1 cycle.
- Section switch costs one bubble cycle (LOAD) with out_valid=0.
- With out_ready held high, a full run takes NUM_SECT·31 cycles from first LOAD to entering DONE, plus one DONE cycle.
  - Example: 16·31 = 496 cycles plus the DONE cycle.
- done asserts the cycle after the edge that accepts the out_last beat. busy drops the cycle after that.
- All outputs are registered or decoded from registered state only. There is no combinational path from out_ready to out_valid.

## Test plan
- Basic run, with the calculator in the loop, corner_b=1000, res=2, NUM_SECT=2, out_ready=1: beats (s0, l0)=1000, (s0, l29)=942, (s1, l0)=940, (s1, l29)=882; out_last only on the 60th beat; done pulses once; 63 cycles from start to IDLE.
- Wrap-around with corner_b=10, res=1: (s0, l10)=0, (s0, l11)=262143, (s0, l29)=262125; all values are 18-bit modular.
- Backpressure: hold out_ready=0 for 5 cycles at (s0, l3). out_data, out_lane and out_sect stay unchanged and no beat is lost. The beat sequence is identical to the no-stall run.
- start pulsed mid-run at (s1, l7): no restart; the sequence continues to (s1, l8); exactly one done pulse.
- n_rst asserted at (s0, l15): all outputs go to 0 asynchronously with no done pulse. After release and a new start, the run begins again at (s0, l0).
- NUM_SECT=1 build: 30 beats; out_last on l29; done one cycle later; sectnum never exceeds 0.
